// File: rtl/sa_feed_ctrl_if.sv
// rtl/sa_feed_ctrl_if.sv - operand, array and result signal bundle for sa_feed_ctrl
// Ports (modport slave = controller view, master = environment view):
//   in_valid/in_ready, in_a_1..3, in_b_1..3 : operand beats (column k of A, row k of B)
//   sa_start, sa_x_1..3, sa_y_1..3          : skewed feeds and run enable to the 3x3 array
//   sa_finish, sa_p_r_c                     : array completion strobe and results
//   out_valid/out_ready, out_p_r_c          : registered product C = A*B
interface sa_feed_ctrl_if #(
  parameter int DW = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [DW-1:0]   in_a_1, in_a_2, in_a_3;
  logic signed [DW-1:0]   in_b_1, in_b_2, in_b_3;
  logic                   sa_start;
  logic signed [DW-1:0]   sa_x_1, sa_x_2, sa_x_3;
  logic signed [DW-1:0]   sa_y_1, sa_y_2, sa_y_3;
  logic                   sa_finish;
  logic signed [2*DW:0]   sa_p_1_1, sa_p_1_2, sa_p_1_3;
  logic signed [2*DW:0]   sa_p_2_1, sa_p_2_2, sa_p_2_3;
  logic signed [2*DW:0]   sa_p_3_1, sa_p_3_2, sa_p_3_3;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [2*DW:0]   out_p_1_1, out_p_1_2, out_p_1_3;
  logic signed [2*DW:0]   out_p_2_1, out_p_2_2, out_p_2_3;
  logic signed [2*DW:0]   out_p_3_1, out_p_3_2, out_p_3_3;

  modport slave (
    input  in_valid, in_a_1, in_a_2, in_a_3, in_b_1, in_b_2, in_b_3,
    output in_ready,
    output sa_start, sa_x_1, sa_x_2, sa_x_3, sa_y_1, sa_y_2, sa_y_3,
    input  sa_finish,
    input  sa_p_1_1, sa_p_1_2, sa_p_1_3, sa_p_2_1, sa_p_2_2, sa_p_2_3,
    input  sa_p_3_1, sa_p_3_2, sa_p_3_3,
    output out_valid,
    input  out_ready,
    output out_p_1_1, out_p_1_2, out_p_1_3, out_p_2_1, out_p_2_2, out_p_2_3,
    output out_p_3_1, out_p_3_2, out_p_3_3
  );

  modport master (
    output in_valid, in_a_1, in_a_2, in_a_3, in_b_1, in_b_2, in_b_3,
    input  in_ready,
    input  sa_start, sa_x_1, sa_x_2, sa_x_3, sa_y_1, sa_y_2, sa_y_3,
    output sa_finish,
    output sa_p_1_1, sa_p_1_2, sa_p_1_3, sa_p_2_1, sa_p_2_2, sa_p_2_3,
    output sa_p_3_1, sa_p_3_2, sa_p_3_3,
    input  out_valid,
    output out_ready,
    input  out_p_1_1, out_p_1_2, out_p_1_3, out_p_2_1, out_p_2_2, out_p_2_3,
    input  out_p_3_1, out_p_3_2, out_p_3_3
  );
endinterface

// File: rtl/sa_feed_ctrl.sv
// rtl/sa_feed_ctrl.sv - loads 3x3 operands, feeds a systolic array skewed, returns C=A*B
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sa_feed_ctrl_if.slave (operand, array and result signals)
//   busy       : controller not in LOAD
//   err        : sticky array-protocol error (finish strobe at the wrong time)
module sa_feed_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  sa_feed_ctrl_if.slave bus,
  output logic          busy,
  output logic          err
);

  localparam int PW = 2*DW+1;

  typedef enum logic [1:0] {LOAD, FEED, OUT} state_t;

  state_t               state_q, state_d;
  logic [1:0]           beat_q;
  logic [2:0]           t_q;
  logic                 err_q;
  logic                 accept, last_beat;
  logic                 feed_en;
  logic [2:0]           feed_t;

  logic signed [DW-1:0] a_q [3][3];   // a_q[row][k]
  logic signed [DW-1:0] b_q [3][3];   // b_q[k][col]
  logic signed [DW-1:0] in_a [3];
  logic signed [DW-1:0] in_b [3];
  logic signed [DW-1:0] x_q [3];
  logic signed [DW-1:0] y_q [3];
  logic signed [DW-1:0] x_d [3];
  logic signed [DW-1:0] y_d [3];
  logic signed [PW-1:0] p_in [3][3];
  logic signed [PW-1:0] p_q [3][3];

  assign in_a[0] = bus.in_a_1;
  assign in_a[1] = bus.in_a_2;
  assign in_a[2] = bus.in_a_3;
  assign in_b[0] = bus.in_b_1;
  assign in_b[1] = bus.in_b_2;
  assign in_b[2] = bus.in_b_3;

  assign p_in[0][0] = bus.sa_p_1_1;
  assign p_in[0][1] = bus.sa_p_1_2;
  assign p_in[0][2] = bus.sa_p_1_3;
  assign p_in[1][0] = bus.sa_p_2_1;
  assign p_in[1][1] = bus.sa_p_2_2;
  assign p_in[1][2] = bus.sa_p_2_3;
  assign p_in[2][0] = bus.sa_p_3_1;
  assign p_in[2][1] = bus.sa_p_3_2;
  assign p_in[2][2] = bus.sa_p_3_3;

  assign accept    = (state_q == LOAD) && bus.in_valid;
  assign last_beat = accept && (beat_q == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (last_beat) state_d = FEED;
      FEED:    if (t_q == 3'd7) state_d = OUT;
      OUT:     if (bus.out_ready) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Feeds are registered, so compute the values for the cycle about to start:
  // t=0 when the third beat is accepted, t+1 while in FEED. Column 0 of A and
  // row 0 of B are already stored by then, which is all t=0 needs.
  always_comb begin
    feed_en = 1'b0;
    feed_t  = 3'd0;
    if (last_beat) begin
      feed_en = 1'b1;
    end else if ((state_q == FEED) && (t_q != 3'd7)) begin
      feed_en = 1'b1;
      feed_t  = t_q + 3'd1;
    end
    for (int i = 0; i < 3; i++) begin
      x_d[i] = '0;
      y_d[i] = '0;
      if (feed_en) begin
        for (int k = 0; k < 3; k++) begin
          // row/column i is delayed by i cycles: index k appears at t = k + i
          if (feed_t == 3'(i + k)) begin
            x_d[i] = a_q[i][k];
            y_d[i] = b_q[k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= 2'd0;
      t_q    <= 3'd0;
      err_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        for (int k = 0; k < 3; k++) begin
          a_q[i][k] <= '0;
          b_q[i][k] <= '0;
          p_q[i][k] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          for (int k = 0; k < 3; k++) begin
            if (beat_q == 2'(k)) begin
              a_q[i][k] <= in_a[i];
              b_q[k][i] <= in_b[i];
            end
          end
        end
        beat_q <= last_beat ? 2'd0 : beat_q + 2'd1;
      end
      if (state_q == FEED) begin
        t_q <= t_q + 3'd1;  // wraps to 0 on leaving FEED
        if (t_q == 3'd7) begin
          // capture unconditionally; a missing finish is only flagged
          for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++)
              p_q[i][k] <= p_in[i][k];
          if (!bus.sa_finish) err_q <= 1'b1;
        end else if (bus.sa_finish) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.sa_start  = (state_q == FEED);
  assign bus.out_valid = (state_q == OUT);
  assign busy          = (state_q != LOAD);
  assign err           = err_q;

  assign bus.sa_x_1 = x_q[0];
  assign bus.sa_x_2 = x_q[1];
  assign bus.sa_x_3 = x_q[2];
  assign bus.sa_y_1 = y_q[0];
  assign bus.sa_y_2 = y_q[1];
  assign bus.sa_y_3 = y_q[2];

  assign bus.out_p_1_1 = p_q[0][0];
  assign bus.out_p_1_2 = p_q[0][1];
  assign bus.out_p_1_3 = p_q[0][2];
  assign bus.out_p_2_1 = p_q[1][0];
  assign bus.out_p_2_2 = p_q[1][1];
  assign bus.out_p_2_3 = p_q[1][2];
  assign bus.out_p_3_1 = p_q[2][0];
  assign bus.out_p_3_2 = p_q[2][1];
  assign bus.out_p_3_3 = p_q[2][2];

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// tb/tb_sa_feed_ctrl.sv - directed self-checking bench for sa_feed_ctrl
module tb_sa_feed_ctrl;
  localparam int DW = 8;
  localparam int PW = 2*DW+1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err;

  sa_feed_ctrl_if #(.DW(DW)) bus ();

  sa_feed_ctrl #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // test matrices and expected product
  int ma [3][3];
  int mb [3][3];
  int ex [3][3];

  // behavioural 3x3 output-stationary systolic array driven by the feeds
  logic signed [PW-1:0] acc [3][3];
  logic signed [DW-1:0] xr [3][3];
  logic signed [DW-1:0] yr [3][3];
  logic signed [DW-1:0] xi, yi;
  logic signed [DW-1:0] fx [3];
  logic signed [DW-1:0] fy [3];
  logic signed [PW-1:0] op [3][3];
  int t_m = 0;
  int fin_t = 7;

  assign fx[0] = bus.sa_x_1;
  assign fx[1] = bus.sa_x_2;
  assign fx[2] = bus.sa_x_3;
  assign fy[0] = bus.sa_y_1;
  assign fy[1] = bus.sa_y_2;
  assign fy[2] = bus.sa_y_3;

  assign bus.sa_p_1_1 = acc[0][0];
  assign bus.sa_p_1_2 = acc[0][1];
  assign bus.sa_p_1_3 = acc[0][2];
  assign bus.sa_p_2_1 = acc[1][0];
  assign bus.sa_p_2_2 = acc[1][1];
  assign bus.sa_p_2_3 = acc[1][2];
  assign bus.sa_p_3_1 = acc[2][0];
  assign bus.sa_p_3_2 = acc[2][1];
  assign bus.sa_p_3_3 = acc[2][2];

  assign op[0][0] = bus.out_p_1_1;
  assign op[0][1] = bus.out_p_1_2;
  assign op[0][2] = bus.out_p_1_3;
  assign op[1][0] = bus.out_p_2_1;
  assign op[1][1] = bus.out_p_2_2;
  assign op[1][2] = bus.out_p_2_3;
  assign op[2][0] = bus.out_p_3_1;
  assign op[2][1] = bus.out_p_3_2;
  assign op[2][2] = bus.out_p_3_3;

  always @(negedge clk) begin
    if (bus.sa_start === 1'b1) begin
      for (int r = 2; r >= 0; r--) begin
        for (int c = 2; c >= 0; c--) begin
          if (c == 0) xi = fx[r];
          else        xi = xr[r][c-1];
          if (r == 0) yi = fy[c];
          else        yi = yr[r-1][c];
          acc[r][c] = acc[r][c] + PW'(xi) * PW'(yi);
          xr[r][c] = xi;
          yr[r][c] = yi;
        end
      end
      bus.sa_finish = (t_m == fin_t);
      t_m++;
    end else begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          acc[r][c] = '0;
          xr[r][c] = '0;
          yr[r][c] = '0;
        end
      end
      bus.sa_finish = 1'b0;
      t_m = 0;
    end
  end

  // drive the three operand beats from ma/mb; call at a negedge in LOAD,
  // returns at the negedge of FEED t=0
  task automatic load3();
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a_1 = DW'(ma[0][k]);
      bus.in_a_2 = DW'(ma[1][k]);
      bus.in_a_3 = DW'(ma[2][k]);
      bus.in_b_1 = DW'(mb[k][0]);
      bus.in_b_2 = DW'(mb[k][1]);
      bus.in_b_3 = DW'(mb[k][2]);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_a_1 = '0; bus.in_a_2 = '0; bus.in_a_3 = '0;
    bus.in_b_1 = '0; bus.in_b_2 = '0; bus.in_b_3 = '0;
    bus.out_ready = 1'b1;
    fin_t = 7;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.sa_start, bus.out_valid, err, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_ctrl: got start/ov/err/busy=%b want 0000", {bus.sa_start, bus.out_valid, err, busy});
    end
    total++;
    if ({fx[0], fx[1], fx[2], fy[0], fy[1], fy[2]} !== 48'd0) begin
      bad++;
      $display("FAIL rst_feeds: got %h want 0", {fx[0], fx[1], fx[2], fy[0], fy[1], fy[2]});
    end
    total++;
    if (op[1][1] !== '0) begin
      bad++;
      $display("FAIL rst_outp: got %0d want 0", op[1][1]);
    end
    rst_n = 1'b1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_identity();
    ma = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    mb = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
    ex = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    bus.out_ready = 1'b1;
    fin_t = 7;
    load3();
    total++;
    if ({bus.sa_start, bus.in_ready, busy} !== 3'b101) begin
      bad++;
      $display("FAIL id_t0_ctrl: got start/ready/busy=%b want 101", {bus.sa_start, bus.in_ready, busy});
    end
    total++;
    if ({fx[0], fx[1], fx[2], fy[0], fy[1], fy[2]} !== {8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0}) begin
      bad++;
      $display("FAIL id_t0_feeds: got %h want 010000010000", {fx[0], fx[1], fx[2], fy[0], fy[1], fy[2]});
    end
    @(negedge clk);
    total++;
    if ({fx[0], fx[1], fx[2]} !== {8'd2, 8'd4, 8'd0}) begin
      bad++;
      $display("FAIL id_t1_x: got %h want 020400", {fx[0], fx[1], fx[2]});
    end
    @(negedge clk);
    total++;
    if ({fx[0], fx[1], fx[2]} !== {8'd3, 8'd5, 8'd7}) begin
      bad++;
      $display("FAIL id_t2_x: got %h want 030507", {fx[0], fx[1], fx[2]});
    end
    repeat (5) @(negedge clk);
    total++;
    if ({bus.sa_start, fx[0], fx[1], fx[2], fy[0], fy[1], fy[2]} !== {1'b1, 48'd0}) begin
      bad++;
      $display("FAIL id_t7: got start+feeds=%h want start=1 feeds 0", {bus.sa_start, fx[0], fx[1], fx[2], fy[0], fy[1], fy[2]});
    end
    @(negedge clk);
    total++;
    if ({bus.sa_start, bus.out_valid, err} !== 3'b010) begin
      bad++;
      $display("FAIL id_out_ctrl: got start/ov/err=%b want 010", {bus.sa_start, bus.out_valid, err});
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        total++;
        if (op[r][c] !== PW'(ex[r][c])) begin
          bad++;
          $display("FAIL id_p_%0d_%0d: got %0d want %0d", r + 1, c + 1, op[r][c], ex[r][c]);
        end
      end
    end
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL id_back_load: got ov/ready/busy=%b want 010", {bus.out_valid, bus.in_ready, busy});
    end
  endtask

  task automatic test_feed_stall();
    bit ok;
    ma = '{'{1, 4, 7}, '{2, 5, 8}, '{3, 6, 9}};
    mb = '{'{1, 1, 0}, '{0, 1, 1}, '{1, 0, 1}};
    ex = '{'{8, 5, 11}, '{10, 7, 13}, '{12, 9, 15}};
    bus.out_ready = 1'b0;
    load3();
    total++;
    if ({fx[0], fx[1], fx[2], fy[0], fy[1], fy[2]} !== {8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0}) begin
      bad++;
      $display("FAIL fs_t0_feeds: got %h want 010000010000", {fx[0], fx[1], fx[2], fy[0], fy[1], fy[2]});
    end
    @(negedge clk);
    total++;
    if ({fy[0], fy[1], fy[2]} !== {8'd0, 8'd1, 8'd0}) begin
      bad++;
      $display("FAIL fs_t1_y: got %h want 000100", {fy[0], fy[1], fy[2]});
    end
    @(negedge clk);
    total++;
    if ({fx[0], fx[1], fx[2]} !== {8'd7, 8'd5, 8'd3}) begin
      bad++;
      $display("FAIL fs_t2_x: got %h want 070503", {fx[0], fx[1], fx[2]});
    end
    wait_out(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL fs_wait_out: got no out_valid want out_valid within 40 cycles");
    end
    for (int n = 0; n < 10; n++) begin
      total++;
      if ({bus.out_valid, bus.in_ready, bus.sa_start} !== 3'b100) begin
        bad++;
        $display("FAIL fs_stall_ctrl_%0d: got ov/ready/start=%b want 100", n, {bus.out_valid, bus.in_ready, bus.sa_start});
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          total++;
          if (op[r][c] !== PW'(ex[r][c])) begin
            bad++;
            $display("FAIL fs_p_%0d_%0d_cyc%0d: got %0d want %0d", r + 1, c + 1, n, op[r][c], ex[r][c]);
          end
        end
      end
      // offered beats while not ready must be dropped
      bus.in_valid = 1'b1;
      bus.in_a_1 = 8'sd99; bus.in_a_2 = 8'sd99; bus.in_a_3 = 8'sd99;
      bus.in_b_1 = 8'sd99; bus.in_b_2 = 8'sd99; bus.in_b_3 = 8'sd99;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.in_ready, err} !== 3'b010) begin
      bad++;
      $display("FAIL fs_release: got ov/ready/err=%b want 010", {bus.out_valid, bus.in_ready, err});
    end
  endtask

  task automatic test_negative();
    bit ok;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = -128;
        mb[r][c] = -128;
        ex[r][c] = 49152;
      end
    end
    bus.out_ready = 1'b1;
    load3();
    wait_out(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL neg_wait_out: got no out_valid want out_valid within 40 cycles");
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        total++;
        if (op[r][c] !== PW'(ex[r][c])) begin
          bad++;
          $display("FAIL neg_p_%0d_%0d: got %0d want %0d", r + 1, c + 1, op[r][c], ex[r][c]);
        end
      end
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL neg_err: got %b want 0", err);
    end
    @(negedge clk);
  endtask

  task automatic test_err();
    bit ok;
    // matrices still all -128 from the previous test
    fin_t = 5;
    load3();
    repeat (5) @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_t5_before: got %b want 0", err);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_early_finish: got %b want 1", err);
    end
    wait_out(ok);
    total++;
    if (!ok || op[2][2] !== PW'(49152)) begin
      bad++;
      $display("FAIL err_early_capture: got ok=%b p33=%0d want ok=1 p33=49152", ok, op[2][2]);
    end
    @(negedge clk);
    total++;
    if ({err, bus.in_ready} !== 2'b11) begin
      bad++;
      $display("FAIL err_sticky: got err/ready=%b want 11", {err, bus.in_ready});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_rst_clear: got %b want 0", err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fin_t = -1;
    load3();
    wait_out(ok);
    total++;
    if (!ok || err !== 1'b1 || op[0][1] !== PW'(49152)) begin
      bad++;
      $display("FAIL err_no_finish: got ok=%b err=%b p12=%0d want ok=1 err=1 p12=49152", ok, err, op[0][1]);
    end
    @(negedge clk);
    fin_t = 7;
  endtask

  task automatic test_reset_mid();
    bit ok;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ma = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    mb = '{'{0, 0, 1}, '{0, 1, 0}, '{1, 0, 0}};
    ex = '{'{3, 2, 1}, '{6, 5, 4}, '{9, 8, 7}};
    bus.out_ready = 1'b1;
    load3();
    repeat (3) @(negedge clk);
    total++;
    if ({fx[0], fx[1], fx[2]} !== {8'd0, 8'd6, 8'd8}) begin
      bad++;
      $display("FAIL rm_t3_x: got %h want 000608", {fx[0], fx[1], fx[2]});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.sa_start, busy, bus.in_ready, fx[0], fx[1], fx[2], fy[0], fy[1], fy[2]} !== {3'b001, 48'd0}) begin
      bad++;
      $display("FAIL rm_async: got start/busy/ready+feeds=%h want ready=1 rest 0", {bus.sa_start, busy, bus.in_ready, fx[0], fx[1], fx[2], fy[0], fy[1], fy[2]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rm_ready_after: got %b want 1", bus.in_ready);
    end
    // one stray beat, then reset must discard it
    bus.in_valid = 1'b1;
    bus.in_a_1 = 8'sd50; bus.in_a_2 = 8'sd50; bus.in_a_3 = 8'sd50;
    bus.in_b_1 = 8'sd50; bus.in_b_2 = 8'sd50; bus.in_b_3 = 8'sd50;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load3();
    wait_out(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rm_wait_out: got no out_valid want out_valid within 40 cycles");
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        total++;
        if (op[r][c] !== PW'(ex[r][c])) begin
          bad++;
          $display("FAIL rm_p_%0d_%0d: got %0d want %0d", r + 1, c + 1, op[r][c], ex[r][c]);
        end
      end
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL rm_err: got %b want 0", err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_feed_stall();
    test_negative();
    test_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
